// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared ALU op codes, operand selects and ID/EX register layout
// Purpose: constants and types shared by the ID/EX stage, its interface and forward unit.
// Ports: none (package).
package id_ex_stage_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_RS2  = 4'd10
    } alu_op_e;

    localparam logic OP_A_RS1 = 1'b0;
    localparam logic OP_A_PC  = 1'b1;
    localparam logic OP_B_RS2 = 1'b0;
    localparam logic OP_B_IMM = 1'b1;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [REG_AW-1:0] rd_addr;
        alu_op_e           alu_op;
        logic              op_a_sel;
        logic              op_b_sel;
        logic              rd_wren;
        logic              is_load;
        logic              is_store;
    } idex_t;

    // Reset value and bubble share one constant: nothing valid, ALU_ADD, zero data.
    localparam idex_t IDEX_BUBBLE = '{
        valid:    1'b0,
        pc:       '0,
        rs1_data: '0,
        rs2_data: '0,
        imm:      '0,
        rs1_addr: '0,
        rs2_addr: '0,
        rd_addr:  '0,
        alu_op:   ALU_ADD,
        op_a_sel: OP_A_RS1,
        op_b_sel: OP_B_RS2,
        rd_wren:  1'b0,
        is_load:  1'b0,
        is_store: 1'b0
    };

    // A source register depends on a writer when the writer is enabled and hits
    // the same non-zero register; x0 never carries a dependency.
    function automatic logic raw_match(input logic [REG_AW-1:0] src,
                                       input logic [REG_AW-1:0] dst,
                                       input logic              dst_wren);
        return dst_wren & (src != '0) & (src == dst);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID/EX stage signal bundle with master/slave modports
// Purpose: groups ID inputs, pipeline control, forwarding sources and EX outputs.
// Ports: master = upstream/environment side, slave = id_ex_stage side.
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    logic              id_valid_i;
    logic [XLEN-1:0]   id_pc_i;
    logic [XLEN-1:0]   id_rs1_data_i;
    logic [XLEN-1:0]   id_rs2_data_i;
    logic [XLEN-1:0]   id_imm_i;
    logic [REG_AW-1:0] id_rs1_addr_i;
    logic [REG_AW-1:0] id_rs2_addr_i;
    logic [REG_AW-1:0] id_rd_addr_i;
    logic [3:0]        id_alu_op_i;
    logic              id_op_a_sel_i;
    logic              id_op_b_sel_i;
    logic              id_rd_wren_i;
    logic              id_is_load_i;
    logic              id_is_store_i;
    logic              stall_i;
    logic              flush_i;
    logic [REG_AW-1:0] exm_rd_addr_i;
    logic              exm_rd_wren_i;
    logic [XLEN-1:0]   exm_data_i;
    logic [REG_AW-1:0] mwb_rd_addr_i;
    logic              mwb_rd_wren_i;
    logic [XLEN-1:0]   mwb_data_i;
    logic              hazard_o;
    logic              ex_valid_o;
    logic [XLEN-1:0]   ex_pc_o;
    logic [XLEN-1:0]   operand_a_o;
    logic [XLEN-1:0]   operand_b_o;
    logic [3:0]        alu_op_o;
    logic [XLEN-1:0]   store_data_o;
    logic [REG_AW-1:0] ex_rd_addr_o;
    logic              ex_rd_wren_o;
    logic              ex_is_load_o;
    logic              ex_is_store_o;

    modport master (
        output id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
               id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_alu_op_i,
               id_op_a_sel_i, id_op_b_sel_i, id_rd_wren_i, id_is_load_i,
               id_is_store_i, stall_i, flush_i, exm_rd_addr_i, exm_rd_wren_i,
               exm_data_i, mwb_rd_addr_i, mwb_rd_wren_i, mwb_data_i,
        input  hazard_o, ex_valid_o, ex_pc_o, operand_a_o, operand_b_o, alu_op_o,
               store_data_o, ex_rd_addr_o, ex_rd_wren_o, ex_is_load_o, ex_is_store_o
    );

    modport slave (
        input  id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
               id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_alu_op_i,
               id_op_a_sel_i, id_op_b_sel_i, id_rd_wren_i, id_is_load_i,
               id_is_store_i, stall_i, flush_i, exm_rd_addr_i, exm_rd_wren_i,
               exm_data_i, mwb_rd_addr_i, mwb_rd_wren_i, mwb_data_i,
        output hazard_o, ex_valid_o, ex_pc_o, operand_a_o, operand_b_o, alu_op_o,
               store_data_o, ex_rd_addr_o, ex_rd_wren_o, ex_is_load_o, ex_is_store_o
    );

endinterface

// File: rtl/id_ex_fwd_unit.sv
// rtl/id_ex_fwd_unit.sv - per-operand forwarding select for the EX stage
// Purpose: picks EX/MEM result, else MEM/WB data, else registered regfile data.
// Ports: rs_addr_i/rs_data_i (registered source), exm_*/mwb_* writer triplets, fwd_data_o.
module id_ex_fwd_unit
    import id_ex_stage_pkg::*;
(
    input  logic [REG_AW-1:0] rs_addr_i,
    input  logic [XLEN-1:0]   rs_data_i,
    input  logic [REG_AW-1:0] exm_rd_addr_i,
    input  logic              exm_rd_wren_i,
    input  logic [XLEN-1:0]   exm_data_i,
    input  logic [REG_AW-1:0] mwb_rd_addr_i,
    input  logic              mwb_rd_wren_i,
    input  logic [XLEN-1:0]   mwb_data_i,
    output logic [XLEN-1:0]   fwd_data_o
);

    // EX/MEM is the younger writer, so it wins over MEM/WB.
    always_comb begin
        fwd_data_o = rs_data_i;
        if (raw_match(rs_addr_i, exm_rd_addr_i, exm_rd_wren_i)) begin
            fwd_data_o = exm_data_i;
        end else if (raw_match(rs_addr_i, mwb_rd_addr_i, mwb_rd_wren_i)) begin
            fwd_data_o = mwb_data_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with EX operand selection and hazard detect
// Purpose: latches ID fields, forwards EX/MEM and MEM/WB results into the ALU operands,
//          raises hazard_o on load-use, handles stall and flush.
// Ports: clk_i, rst_ni (async active-low), bus (id_ex_stage_if.slave).
// Config: ID_EX_FWD_EN defined enables forwarding; undefined, every RAW dependency
//         against EX, EX/MEM or MEM/WB is resolved by hazard_o instead.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    id_ex_stage_if.slave  bus
);

`ifdef ID_EX_FWD_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif

    idex_t           ex_q, ex_d;
    logic            load_use, raw_stall, hazard;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    always_comb begin
        load_use = ex_q.valid & ex_q.is_load & bus.id_valid_i &
                   (raw_match(bus.id_rs1_addr_i, ex_q.rd_addr, 1'b1) |
                    raw_match(bus.id_rs2_addr_i, ex_q.rd_addr, 1'b1));
`ifdef ID_EX_FWD_EN
        raw_stall = 1'b0;
`else
        // Without forwarding, any in-flight writer of an ID source must drain first.
        raw_stall = bus.id_valid_i &
            (raw_match(bus.id_rs1_addr_i, ex_q.rd_addr, ex_q.valid & ex_q.rd_wren) |
             raw_match(bus.id_rs1_addr_i, bus.exm_rd_addr_i, bus.exm_rd_wren_i) |
             raw_match(bus.id_rs1_addr_i, bus.mwb_rd_addr_i, bus.mwb_rd_wren_i) |
             raw_match(bus.id_rs2_addr_i, ex_q.rd_addr, ex_q.valid & ex_q.rd_wren) |
             raw_match(bus.id_rs2_addr_i, bus.exm_rd_addr_i, bus.exm_rd_wren_i) |
             raw_match(bus.id_rs2_addr_i, bus.mwb_rd_addr_i, bus.mwb_rd_wren_i));
`endif
        // The ID instruction is being discarded on flush, so it cannot stall anything.
        hazard = ~bus.flush_i & (load_use | raw_stall);
    end

    always_comb begin
        ex_d = ex_q;
        if (bus.flush_i) begin
            ex_d = IDEX_BUBBLE;
        end else if (bus.stall_i) begin
            ex_d = ex_q;
        end else if (hazard) begin
            ex_d = IDEX_BUBBLE;
        end else begin
            ex_d.valid    = bus.id_valid_i;
            ex_d.pc       = bus.id_pc_i;
            ex_d.rs1_data = bus.id_rs1_data_i;
            ex_d.rs2_data = bus.id_rs2_data_i;
            ex_d.imm      = bus.id_imm_i;
            ex_d.rs1_addr = bus.id_rs1_addr_i;
            ex_d.rs2_addr = bus.id_rs2_addr_i;
            ex_d.rd_addr  = bus.id_rd_addr_i;
            ex_d.alu_op   = alu_op_e'(bus.id_alu_op_i);
            ex_d.op_a_sel = bus.id_op_a_sel_i;
            ex_d.op_b_sel = bus.id_op_b_sel_i;
            ex_d.rd_wren  = bus.id_rd_wren_i  & bus.id_valid_i;
            ex_d.is_load  = bus.id_is_load_i  & bus.id_valid_i;
            ex_d.is_store = bus.id_is_store_i & bus.id_valid_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_q <= IDEX_BUBBLE;
        end else begin
            ex_q <= ex_d;
        end
    end

    id_ex_fwd_unit u_fwd_rs1 (
        .rs_addr_i     (ex_q.rs1_addr),
        .rs_data_i     (ex_q.rs1_data),
        .exm_rd_addr_i (bus.exm_rd_addr_i),
        .exm_rd_wren_i (bus.exm_rd_wren_i & FWD_EN),
        .exm_data_i    (bus.exm_data_i),
        .mwb_rd_addr_i (bus.mwb_rd_addr_i),
        .mwb_rd_wren_i (bus.mwb_rd_wren_i & FWD_EN),
        .mwb_data_i    (bus.mwb_data_i),
        .fwd_data_o    (fwd_rs1)
    );

    id_ex_fwd_unit u_fwd_rs2 (
        .rs_addr_i     (ex_q.rs2_addr),
        .rs_data_i     (ex_q.rs2_data),
        .exm_rd_addr_i (bus.exm_rd_addr_i),
        .exm_rd_wren_i (bus.exm_rd_wren_i & FWD_EN),
        .exm_data_i    (bus.exm_data_i),
        .mwb_rd_addr_i (bus.mwb_rd_addr_i),
        .mwb_rd_wren_i (bus.mwb_rd_wren_i & FWD_EN),
        .mwb_data_i    (bus.mwb_data_i),
        .fwd_data_o    (fwd_rs2)
    );

    assign bus.hazard_o      = hazard;
    assign bus.ex_valid_o    = ex_q.valid;
    assign bus.ex_pc_o       = ex_q.pc;
    assign bus.operand_a_o   = (ex_q.op_a_sel == OP_A_PC)  ? ex_q.pc  : fwd_rs1;
    assign bus.operand_b_o   = (ex_q.op_b_sel == OP_B_IMM) ? ex_q.imm : fwd_rs2;
    assign bus.alu_op_o      = ex_q.alu_op;
    assign bus.store_data_o  = fwd_rs2;
    assign bus.ex_rd_addr_o  = ex_q.rd_addr;
    assign bus.ex_rd_wren_o  = ex_q.rd_wren;
    assign bus.ex_is_load_o  = ex_q.is_load;
    assign bus.ex_is_store_o = ex_q.is_store;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-side operand selection directly upstream of the ALU.
- Latches decoded fields from ID, applies EX/MEM and MEM/WB forwarding, and drives operand_a_o, operand_b_o and alu_op_o straight into the ALU operand/op inputs.
- Detects load-use hazards against the instruction it holds and inserts bubbles.
- Handles pipeline stall and flush (branch redirect).

Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register address width

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- id_valid_i  in  1  ID holds a valid instruction
- id_pc_i  in  XLEN  instruction PC
- id_rs1_data_i, id_rs2_data_i  in  XLEN  regfile read data
- id_imm_i  in  XLEN  sign-extended immediate
- id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i  in  REG_AW  register addresses
- id_alu_op_i  in  4  ALU op code (shared constants)
- id_op_a_sel_i  in  1  0=rs1, 1=PC
- id_op_b_sel_i  in  1  0=rs2, 1=imm
- id_rd_wren_i, id_is_load_i, id_is_store_i  in  1  control
- stall_i  in  1  EX frozen by downstream
- flush_i  in  1  kill instruction entering EX (branch taken)
- exm_rd_addr_i  in  REG_AW  EX/MEM destination
- exm_rd_wren_i  in  1  EX/MEM writes rd
- exm_data_i  in  XLEN  EX/MEM ALU result
- mwb_rd_addr_i  in  REG_AW  MEM/WB destination
- mwb_rd_wren_i  in  1  MEM/WB writes rd
- mwb_data_i  in  XLEN  MEM/WB writeback data
- hazard_o  out  1  load-use hazard; ID/IF must hold
- ex_valid_o  out  1  EX instruction valid
- ex_pc_o  out  XLEN  registered PC
- operand_a_o, operand_b_o  out  XLEN  ALU operands
- alu_op_o  out  4  ALU op
- store_data_o  out  XLEN  forwarded rs2 for stores
- ex_rd_addr_o  out  REG_AW  registered rd
- ex_rd_wren_o, ex_is_load_o, ex_is_store_o  out  1  registered control

Behaviour:
- Reset (rst_ni low, asynchronous):
  - All registers clear.
  - ex_valid_o, ex_rd_wren_o, ex_is_load_o, ex_is_store_o = 0.
  - alu_op_o = ALU_ADD, ex_rd_addr_o = 0.
  - Operands 0, store_data_o 0, hazard_o 0.
- Latency: one cycle from ID inputs to EX outputs. Forwarding muxes are combinational after the register.
- Register update priority each rising edge:
  1. flush_i: load bubble (valid=0, rd_wren=0, is_load=0, is_store=0, alu_op=ALU_ADD). Applies even if stall_i is set.
  2. stall_i: hold all registers.
  3. hazard_o: load bubble.
  4. Otherwise: load ID fields. valid = id_valid_i. All control bits are ANDed with id_valid_i.
- hazard_o is combinational: ex_valid_o & ex_is_load_o & ex_rd_addr_o!=0 & id_valid_i & (ex_rd_addr_o==id_rs1_addr_i | ex_rd_addr_o==id_rs2_addr_i). It is computed regardless of stall_i and forced to 0 while flush_i=1.
- Forwarding for rs1 and rs2 independently:
  - Select exm_data_i if exm_rd_wren_i & exm_rd_addr_i==rs & rs!=0.
  - Else select mwb_data_i if mwb_rd_wren_i & mwb_rd_addr_i==rs & rs!=0.
  - Else use the registered regfile data.
  - EX/MEM takes priority over MEM/WB. x0 is never forwarded.
- operand_a_o = op_a_sel ? ex_pc_o : fwd_rs1. operand_b_o = op_b_sel ? imm : fwd_rs2. store_data_o = fwd_rs2 always.
- A bubble presents ALU_ADD with whatever operands are registered. Consumers gate on ex_valid_o.

Optional Feature:
- Macro: ID_EX_FWD_EN.
- Defined: forwarding as above; hazard_o covers load-use only.
- Undefined:
  - exm_*/mwb_* data inputs are unused for data selection; operands come from registered regfile data.
  - hazard_o additionally asserts on any RAW match of a valid ID source (non-zero) against ex_rd_addr_o (when ex_valid_o & ex_rd_wren_o), exm_rd_addr_i (when exm_rd_wren_i), or mwb_rd_addr_i (when mwb_rd_wren_i).

Decomposition:
- Shared package holds:
  - ALU op codes (ALU_ADD..ALU_RS2, 4-bit).
  - op_a_sel/op_b_sel encodings.
  - Bubble constant struct for the ID/EX register.
- One sub-module: id_ex_fwd_unit. Combinational per-operand forward select with inputs rs addr, reg data, exm/mwb triplets; output forwarded data. Instantiated twice (rs1, rs2).

Test Plan:
- Reset: drive rst_ni=0 mid-cycle with valid instruction held -> outputs clear immediately (asynchronous); ex_valid_o=0, alu_op_o=ALU_ADD.
- ADD x3,x1,x2 with rs1=5, rs2=7, no matches -> next cycle operand_a_o=5, operand_b_o=7, ex_rd_addr_o=3, ex_valid_o=1.
- Double forward: rs1=x4 with exm_rd=4 (data 0x11) and mwb_rd=4 (data 0x22), both wren -> operand_a_o=0x11. Repeat with rs=x0 -> registered data used.
- Load-use: EX holds LW x5, ID ADDI x6,x5,1 -> hazard_o=1. Next cycle ex_valid_o=0 and ex_rd_wren_o=0. Then, with ID held, hazard_o=0 and ADDI loads.
- Flush vs stall: flush_i=1 and stall_i=1 together -> next cycle ex_valid_o=0. stall_i alone for 3 cycles -> outputs unchanged.
- Without ID_EX_FWD_EN: exm_rd=2 wren, ID reads x2 -> hazard_o=1 and operand uses regfile data. With the macro: hazard_o=0 and operand = exm_data_i.
